// File: rtl/axi_slice_dc_chan_writer.sv
// Write end of a token-based dual-clock AXI slice channel; optional stall counter under AXI_SLICE_DC_STALL_CNT_EN.
// Latency: accepted beat and its writetoken toggle are visible at the next clk_i edge.
// Backpressure: ready_o drops when the slot under wr_ptr is occupied or the drain/isolate FSM leaves RUN.
module axi_slice_dc_chan_writer #(
    parameter int DATA_WIDTH   = 64,
    parameter int BUFFER_WIDTH = 8,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [DATA_WIDTH-1:0]              data_i,
    input  logic                               valid_i,
    output logic                               ready_o,
    output logic [BUFFER_WIDTH*DATA_WIDTH-1:0] async_data_o,
    output logic [BUFFER_WIDTH-1:0]            async_writetoken_o,
    input  logic [BUFFER_WIDTH-1:0]            async_readpointer_i,
    input  logic                               isolate_i,
    output logic                               isolated_o,
    output logic [$clog2(BUFFER_WIDTH+1)-1:0]  fill_o,
    output logic [15:0]                        stall_cnt_o
);
    localparam int FILL_W = $clog2(BUFFER_WIDTH+1);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_ISOLATED
    } state_t;

    state_t                  state_q, state_d;
    logic [BUFFER_WIDTH-1:0] wr_ptr_q;
    logic [BUFFER_WIDTH-1:0] writetoken_q;
    logic [BUFFER_WIDTH-1:0] rp_sync_q [SYNC_STAGES];
    logic [DATA_WIDTH-1:0]   slot_q    [BUFFER_WIDTH];
    logic [BUFFER_WIDTH-1:0] occ;
    logic [FILL_W-1:0]       fill;
    logic                    full;
    logic                    empty;
    logic                    accept;

    // A slot is occupied while our token and the reader's pointer disagree.
    assign occ    = writetoken_q ^ rp_sync_q[SYNC_STAGES-1];
    assign full   = |(occ & wr_ptr_q);
    assign empty  = (fill == '0);
    assign accept = valid_i & ready_o;

    always_comb begin
        fill = '0;
        for (int i = 0; i < BUFFER_WIDTH; i++) begin
            fill = fill + FILL_W'(occ[i]);
        end
    end

    assign ready_o            = (state_q == ST_RUN) & ~full;
    assign isolated_o         = (state_q == ST_ISOLATED);
    assign fill_o             = fill;
    assign async_writetoken_o = writetoken_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                rp_sync_q[s] <= '0;
            end
        end else begin
            rp_sync_q[0] <= async_readpointer_i;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                rp_sync_q[s] <= rp_sync_q[s-1];
            end
        end
    end

    // Only one token bit flips per accept, so the far side can sample the vector safely.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q     <= BUFFER_WIDTH'(1);
            writetoken_q <= '0;
        end else if (accept) begin
            wr_ptr_q     <= {wr_ptr_q[BUFFER_WIDTH-2:0], wr_ptr_q[BUFFER_WIDTH-1]};
            writetoken_q <= writetoken_q ^ wr_ptr_q;
        end
    end

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < BUFFER_WIDTH; i++) begin
            if (rst_i) begin
                slot_q[i] <= '0;
            end else if (accept && wr_ptr_q[i]) begin
                slot_q[i] <= data_i;
            end
        end
    end

    for (genvar g = 0; g < BUFFER_WIDTH; g++) begin : g_data
        assign async_data_o[g*DATA_WIDTH +: DATA_WIDTH] = slot_q[g];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (isolate_i) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!isolate_i)  state_d = ST_RUN;
                else if (empty)  state_d = ST_ISOLATED;
            end
            ST_ISOLATED: begin
                if (!isolate_i) state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

`ifdef AXI_SLICE_DC_STALL_CNT_EN
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
        end else if (valid_i && !ready_o && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`else
    assign stall_cnt_o = 16'h0000;
`endif

endmodule
